// File: rtl/fp_pkg.sv
// Shared widths, constants and types for the floating-point add/sub normalizer.
package fp_pkg;

  localparam int unsigned SIZE_DATA = 28;
  localparam int unsigned SIZE_EXP  = 8;

  localparam logic [SIZE_EXP-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

  // Result payload presented to the rounding stage
  typedef struct packed {
    logic [SIZE_DATA-1:0] mant;
    logic [SIZE_EXP-1:0]  exp;
    logic                 zero;
    logic                 underflow;
    logic                 overflow;
  } norm_res_t;

endpackage : fp_pkg

// File: rtl/mant_norm_seq_if.sv
// Operand/result handshake bundle between the mantissa adder, normalizer and rounder.
interface mant_norm_seq_if;
  import fp_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic                 i_carry;
  logic [SIZE_DATA-1:0] i_sum;
  logic [SIZE_EXP-1:0]  i_exp;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_mant;
  logic [SIZE_EXP-1:0]  o_exp;
  logic                 o_zero;
  logic                 o_underflow;
  logic                 o_overflow;

  modport slave (
    input  i_valid, i_carry, i_sum, i_exp, i_ready,
    output o_ready, o_valid, o_mant, o_exp, o_zero, o_underflow, o_overflow
  );

  modport master (
    output i_valid, i_carry, i_sum, i_exp, i_ready,
    input  o_ready, o_valid, o_mant, o_exp, o_zero, o_underflow, o_overflow
  );

endinterface : mant_norm_seq_if

// File: rtl/mant_norm_seq.sv
// Iterative mantissa normalizer: one-step right shift on carry overflow,
// one left shift per cycle on cancellation, bounded by the denormal boundary.
module mant_norm_seq
  import fp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  mant_norm_seq_if.slave   bus
);

  norm_state_e          state_q, state_d;
  norm_res_t            res_q, res_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [SIZE_EXP-1:0]  exp_inc;

  assign exp_inc = SIZE_EXP'(bus.i_exp + SIZE_EXP'(1));

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          res_d   = '0;
          state_d = DONE;
          if (bus.i_exp == EXP_MAX) begin
            res_d.mant = bus.i_sum;
            res_d.exp  = bus.i_exp;
          end else if (bus.i_carry) begin
            res_d.exp = exp_inc;
            if (exp_inc == EXP_MAX) begin
              res_d.overflow = 1'b1;
            end else begin
              res_d.mant = {1'b1, bus.i_sum[SIZE_DATA-1:2], bus.i_sum[1] | bus.i_sum[0]};
            end
          end else if (bus.i_sum == '0) begin
            res_d.zero = 1'b1;
          end else if (bus.i_exp == '0) begin
            res_d.mant = bus.i_sum;
          end else begin
            res_d.mant = bus.i_sum;
            res_d.exp  = bus.i_exp;
            state_d    = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (res_q.mant[SIZE_DATA-1]) begin
          state_d = DONE;
        end else if (res_q.exp == SIZE_EXP'(1)) begin
          // Hit the denormal boundary: stop without shifting further
          res_d.exp       = '0;
          res_d.underflow = 1'b1;
          state_d         = DONE;
        end else begin
          res_d.mant = {res_q.mant[SIZE_DATA-2:0], 1'b0};
          res_d.exp  = SIZE_EXP'(res_q.exp - SIZE_EXP'(1));
        end
      end

      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // FSM and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_mant      = res_q.mant;
  assign bus.o_exp       = res_q.exp;
  assign bus.o_zero      = res_q.zero;
  assign bus.o_underflow = res_q.underflow;
  assign bus.o_overflow  = res_q.overflow;

endmodule : mant_norm_seq

// File: doc/mant_norm_seq.md
# mant_norm_seq

Iterative mantissa normalizer for the floating-point add/sub datapath. Consumes the raw `{carry, sum}` result of the 28-bit mantissa adder together with the pre-add exponent. Produces a normalized 28-bit mantissa (hidden bit at MSB, guard/round/sticky in the low bits) and an adjusted exponent for the rounding stage. Carry overflow is handled in one right shift; cancellation is handled by one left shift per cycle behind a valid/ready handshake.

## Interface
- `SIZE_DATA`, 28, mantissa width; MSB is the hidden-bit position.
- `SIZE_EXP`, 8, exponent width.
- `i_clk`  in  1  single clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_valid`  in  1  upstream operand valid.
- `o_ready`  out  1  block can accept a new operand.
- `i_carry`  in  1  adder carry-out.
- `i_sum`  in  SIZE_DATA  adder sum.
- `i_exp`  in  SIZE_EXP  exponent before normalization.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_mant`  out  SIZE_DATA  normalized mantissa.
- `o_exp`  out  SIZE_EXP  adjusted exponent.
- `o_zero`  out  1  result is exact zero.
- `o_underflow`  out  1  normalization stopped at the denormal boundary.
- `o_overflow`  out  1  exponent saturated to all-ones, which encodes infinity.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- `o_ready` is 1 only in IDLE. An operand is accepted when `i_valid && o_ready`. Inputs are ignored in every other cycle.
- On accept, classify the operand in this priority order:
  1. `i_exp == 8'hFF`: pass through unchanged and drop the carry. Go to DONE with no flags set.
  2. `i_carry == 1`:
     - Result mantissa is `{1'b1, i_sum[27:2], i_sum[1] | i_sum[0]}`; the low bit is the sticky bit.
     - Result exponent is `i_exp + 1`.
     - If `i_exp + 1 == 8'hFF`: force `o_mant = 0` and set `o_overflow`.
     - Go to DONE.
  3. `i_sum == 0`: result is mantissa 0, exponent 0, with `o_zero` set. Go to DONE.
  4. `i_exp == 0`: the operand is already denormal. Pass through unchanged and go to DONE.
  5. Otherwise: load the mantissa and exponent registers and go to SHIFT.
- Each cycle in SHIFT:
  - If `mant[27] == 1`: go to DONE.
  - Else if `exp == 1`: set exponent to 0, set `o_underflow`, leave the mantissa unshifted, and go to DONE.
  - Else: shift the mantissa left by 1 (zero fill) and decrement the exponent.
- In DONE, `o_valid` is 1 and all outputs are held stable until `i_ready`. On `o_valid && i_ready`, go to IDLE. The next accept is possible in the following cycle, so there is no overlap with the output handshake.
- Flags are mutually exclusive and are cleared on every accept.
- Arithmetic is unsigned. The exponent never wraps: it is bounded by the 8'hFF check and the `exp == 1` stop.

## Timing
- Reset values: state IDLE, `o_ready = 1`, `o_valid = 0`, `o_mant = 0`, `o_exp = 0`, all flags 0.
- Latency from the accept edge to `o_valid`:
  - 1 cycle for classification cases 1–4.
  - n+2 cycles for case 5, where n is the number of left shifts performed (0..27).
- Worst case is 29 cycles. Throughput is one result per latency + 1 cycles, assuming `i_ready` is held high.
- Backpressure: DONE lasts indefinitely while `i_ready` is 0. Outputs do not change and `o_ready` stays 0.
- Reset asserted mid-operation: the block returns to IDLE immediately and asynchronously. The in-flight operand is discarded and outputs take their reset values; no partial result is emitted.
- `i_valid` high while `o_ready` is 0 has no effect; upstream must hold its data.

## Structure
- Shared package `fp_pkg`: `SIZE_DATA`, `SIZE_EXP`, constant `EXP_MAX = 8'hFF`, and the enum `norm_state_e` {IDLE, SHIFT, DONE}.
- No sub-module. Sticky OR, increment/decrement and the single-bit shift are inline.
- The FSM and the datapath registers sit in one `always_ff` with asynchronous reset.

## Test plan
- Shift by 5: `i_exp = 100`, `i_sum = 28'h0400000`, `i_carry = 0`. Expect `o_mant = 28'h8000000`, `o_exp = 95`, `o_valid` exactly 7 cycles after accept.
- Carry with sticky: `i_carry = 1`, `i_sum = 28'h0000001`, `i_exp = 10`. Expect `o_mant = 28'h8000001`, `o_exp = 11`, latency 1.
- Underflow: `i_exp = 3`, `i_sum = 28'h0000100`. Expect `o_mant = 28'h0000400`, `o_exp = 0`, `o_underflow = 1`, latency 4.
- Overflow and zero:
  - `i_carry = 1`, `i_exp = 254`: expect `o_exp = 8'hFF`, `o_mant = 0`, `o_overflow = 1`.
  - `i_sum = 0`, `i_carry = 0`: expect `o_zero = 1`, `o_exp = 0`.
- Backpressure: hold `i_ready = 0` for 5 cycles in DONE. Outputs must stay stable, `o_ready` must stay 0, and a concurrent `i_valid` must be ignored.
- Reset mid-SHIFT: assert `i_rst_n = 0` during the 3rd shift cycle of the first scenario. `o_valid` must go to 0 and `o_ready` must rise immediately. After release, a fresh operand must produce the correct result.
